// File: rtl/wb_prog_loader_if.sv
// Byte-stream and Wishbone signals of the boot-image loader.
// The loader drives through the master modport; the serial front end and
// the SRAM slave drive through the slave modport.
interface wb_prog_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [7:0]  wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;

  modport master (
    input  byte_valid, byte_data, wbm_ack_i,
    output byte_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
           wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output byte_valid, byte_data, wbm_ack_i,
    input  byte_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
           wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_prog_loader.sv
// Boot-image loader: takes a word count byte followed by 4*N little-endian
// data bytes, writes each packed word to SRAM with Wishbone classic single
// writes at consecutive word addresses from 0, then releases the core reset.
// A write that sees no ack for TIMEOUT cycles aborts into a sticky error.
module wb_prog_loader #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_prog_loader_if.master    bus,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                core_rst,
  output logic [8:0]          words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  // Last count value that still waits; the edge seeing it without ack aborts.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  n_q, n_d;          // word count, 0 means 256
  logic [1:0]  idx_q, idx_d;      // byte lane of the word being assembled
  logic [7:0]  addr_q, addr_d;    // current word address
  logic [31:0] word_q, word_d;    // assembled write data
  logic [15:0] tcnt_q, tcnt_d;    // cycles spent waiting for ack
  logic [8:0]  wl_q, wl_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        cyc_q, cyc_d;
  logic        core_rst_q, core_rst_d;
  logic        accept;

  // Handshake and busy decode straight from the state register.
  assign bus.byte_ready = (state_q == S_IDLE) || (state_q == S_COLLECT);
  assign busy           = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign accept         = bus.byte_valid && bus.byte_ready;

  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = cyc_q;
  assign bus.wbm_sel_o = {4{cyc_q}};
  assign bus.wbm_adr_o = addr_q;
  assign bus.wbm_dat_o = word_q;
  assign done          = done_q;
  assign error         = error_q;
  assign core_rst      = core_rst_q;
  assign words_loaded  = wl_q;

  // Next-state and next-register computation for the load sequence.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    word_d     = word_q;
    tcnt_d     = tcnt_q;
    wl_d       = wl_q;
    done_d     = done_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          n_d     = bus.byte_data;
          idx_d   = 2'd0;
          addr_d  = 8'd0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          case (idx_q)
            2'd0:    word_d[7:0]   = bus.byte_data;
            2'd1:    word_d[15:8]  = bus.byte_data;
            2'd2:    word_d[23:16] = bus.byte_data;
            default: word_d[31:24] = bus.byte_data;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            tcnt_d  = 16'd0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (bus.wbm_ack_i) begin
          wl_d = wl_q + 9'd1;
          // 8-bit compare: a count byte of 0 wraps so the last address is 255.
          if (addr_q == (n_q - 8'd1)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = S_COLLECT;
          end
        end else if (tcnt_q == TO_LAST) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          wl_d    = 9'd0;
          idx_d   = 2'd0;
          addr_d  = 8'd0;
          word_d  = 32'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cyc_d      = (state_d == S_WRITE);
    core_rst_d = (state_d != S_DONE);
  end

  // State and output registers; reset abandons any partial word or write.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      n_q        <= 8'd0;
      idx_q      <= 2'd0;
      addr_q     <= 8'd0;
      word_q     <= 32'd0;
      tcnt_q     <= 16'd0;
      wl_q       <= 9'd0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cyc_q      <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      tcnt_q     <= tcnt_d;
      wl_q       <= wl_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cyc_q      <= cyc_d;
      core_rst_q <= core_rst_d;
    end
  end

endmodule

// File: tb/tb_wb_prog_loader.sv
// Directed bench for wb_prog_loader: byte source and Wishbone slave are
// modelled cycle by cycle; completed writes are collected and compared with
// hand-computed words.
module tb_wb_prog_loader;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, error, core_rst;
  logic [8:0] words_loaded;

  wb_prog_loader_if bus ();

  wb_prog_loader #(.TIMEOUT(16)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .bus          (bus),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .core_rst     (core_rst),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  stream [$];
  logic [7:0]  wr_adr [$];
  logic [31:0] wr_dat [$];
  int          max_run;
  int          ready_in_write;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives the stream, answers writes ack_lat cycles into stb (0 = never).
  task automatic run_stream(input int ack_lat, input bit rnd, input int budget);
    int bi = 0;
    int scnt = 0;
    int run = 0;
    int cyc = 0;
    bit prev_acc = 1'b0;
    bit fin = 1'b0;
    bit completed = 1'b0;
    wr_adr.delete();
    wr_dat.delete();
    max_run = 0;
    ready_in_write = 0;
    while (!fin) begin
      @(posedge clk);
      #1;
      cyc++;
      if (prev_acc) bi++;
      if (bus.wbm_stb_o) begin
        run++;
        scnt++;
        if (run > max_run) max_run = run;
        if (bus.byte_ready) ready_in_write++;
      end else begin
        run = 0;
        scnt = 0;
      end
      bus.wbm_ack_i = bus.wbm_stb_o && (ack_lat != 0) && (scnt == ack_lat);
      if (bus.wbm_ack_i) begin
        wr_adr.push_back(bus.wbm_adr_o);
        wr_dat.push_back(bus.wbm_dat_o);
      end
      if (bi < stream.size()) begin
        bus.byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.byte_data  = stream[bi];
      end else begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'hA5;
      end
      prev_acc = bus.byte_valid && bus.byte_ready;
      if (done || error || (bi == stream.size() && !bus.wbm_stb_o)) begin
        fin = 1'b1;
        completed = 1'b1;
      end else if (cyc >= budget) begin
        fin = 1'b1;
      end
    end
    bus.byte_valid = 1'b0;
    bus.wbm_ack_i  = 1'b0;
    chk("run_complete", {31'd0, completed}, 32'd1);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic load_two_words();
    stream.delete();
    stream = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  endtask

  task automatic check_two_words(input string p);
    chk({p, "_nwr"},  32'(wr_adr.size()), 32'd2);
    chk({p, "_adr0"}, (wr_adr.size() > 0) ? 32'(wr_adr[0]) : 32'hFFFF_FFFF, 32'h0);
    chk({p, "_dat0"}, (wr_dat.size() > 0) ? wr_dat[0] : 32'hFFFF_FFFF, 32'h1234_5678);
    chk({p, "_adr1"}, (wr_adr.size() > 1) ? 32'(wr_adr[1]) : 32'hFFFF_FFFF, 32'h1);
    chk({p, "_dat1"}, (wr_dat.size() > 1) ? wr_dat[1] : 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    chk({p, "_done"}, {31'd0, done}, 32'd1);
    chk({p, "_core_rst"}, {31'd0, core_rst}, 32'd0);
    chk({p, "_words"}, 32'(words_loaded), 32'd2);
    chk({p, "_ready_in_write"}, 32'(ready_in_write), 32'd0);
    chk({p, "_ready_done"}, {31'd0, bus.byte_ready}, 32'd0);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.wbm_ack_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.byte_ready}, 32'd1);
    chk("rst_cyc_stb", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'd0);
    chk("rst_sel_we", {27'd0, bus.wbm_sel_o, bus.wbm_we_o}, 32'd0);
    chk("rst_adr", 32'(bus.wbm_adr_o), 32'd0);
    chk("rst_dat", bus.wbm_dat_o, 32'd0);
    chk("rst_flags", {28'd0, busy, done, error, core_rst}, 32'h1);
    chk("rst_words", 32'(words_loaded), 32'd0);

    // start coincident with reset release must be ignored
    rst = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_at_rel_idle", {30'd0, bus.byte_ready, busy}, 32'h2);

    // Basic two-word load, valid held high, registered slave
    load_two_words();
    run_stream(2, 1'b0, 300);
    check_two_words("basic");
    chk("basic_stb_len", 32'(max_run), 32'd2);
    pulse_start();
    chk("restart_flags", {29'd0, done, error, core_rst}, 32'h1);
    chk("restart_words", 32'(words_loaded), 32'd0);

    // Gappy stream and slow slave
    load_two_words();
    run_stream(5, 1'b1, 600);
    check_two_words("gappy");
    chk("gappy_stb_len", 32'(max_run), 32'd5);
    pulse_start();

    // N=0 encodes 256 words
    stream.delete();
    stream.push_back(8'h00);
    for (int i = 0; i < 1024; i++) stream.push_back(8'(i));
    run_stream(2, 1'b0, 4000);
    chk("n256_nwr", 32'(wr_adr.size()), 32'd256);
    chk("n256_last_adr", (wr_adr.size() == 256) ? 32'(wr_adr[255]) : 32'hFFFF_FFFF, 32'hFF);
    chk("n256_last_dat", (wr_dat.size() == 256) ? wr_dat[255] : 32'hFFFF_FFFF, 32'hFFFE_FDFC);
    bad = 0;
    for (int w = 0; w < wr_dat.size(); w++) begin
      if (wr_dat[w] !== {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)} || wr_adr[w] !== 8'(w)) bad++;
    end
    chk("n256_bad_words", 32'(bad), 32'd0);
    chk("n256_words", 32'(words_loaded), 32'd256);
    chk("n256_done", {31'd0, done}, 32'd1);
    pulse_start();

    // Slave never acks: abort after 16 stb cycles
    stream.delete();
    stream = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    run_stream(0, 1'b0, 300);
    chk("to_stb_len", 32'(max_run), 32'd16);
    chk("to_error", {31'd0, error}, 32'd1);
    chk("to_cyc_stb", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'd0);
    chk("to_core_rst_done", {30'd0, core_rst, done}, 32'h2);
    chk("to_words", 32'(words_loaded), 32'd0);
    pulse_start();
    chk("to_clear", {29'd0, error, bus.byte_ready, busy}, 32'h2);

    // Asynchronous reset in the middle of word 1 of a 3-word load
    stream.delete();
    stream = '{8'h03, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
    run_stream(2, 1'b0, 300);
    chk("mid_words_before", 32'(words_loaded), 32'd1);
    chk("mid_adr_before", 32'(bus.wbm_adr_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_words", 32'(words_loaded), 32'd0);
    chk("mid_rst_adr_dat", {bus.wbm_adr_o, 24'd0} | bus.wbm_dat_o, 32'd0);
    chk("mid_rst_flags", {27'd0, bus.byte_ready, busy, done, error, core_rst}, 32'h11);
    @(posedge clk);
    #1;
    rst = 1'b0;
    load_two_words();
    run_stream(2, 1'b0, 300);
    check_two_words("after_rst");

    // Ack on the very edge the timeout would fire: write wins
    rst = 1'b1;
    #3;
    rst = 1'b0;
    stream.delete();
    stream = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12};
    run_stream(16, 1'b0, 300);
    chk("race_stb_len", 32'(max_run), 32'd16);
    chk("race_words", 32'(words_loaded), 32'd1);
    chk("race_error", {31'd0, error}, 32'd0);
    chk("race_collect", {30'd0, busy, bus.byte_ready}, 32'h3);
    chk("race_dat", (wr_dat.size() > 0) ? wr_dat[0] : 32'hFFFF_FFFF, 32'h1234_5678);

    // Stray ack outside WRITE does nothing
    bus.wbm_ack_i = 1'b1;
    @(posedge clk);
    #1;
    bus.wbm_ack_i = 1'b0;
    @(posedge clk);
    #1;
    chk("stray_ack_words", 32'(words_loaded), 32'd1);
    chk("stray_ack_stb", {31'd0, bus.wbm_stb_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
